// File: rtl/vliw_rf_pkg.sv
// vliw_rf_pkg: shared constants and types for the VLIW unified register file.
//   - Register map: 0..31 integer, NREG/2..NREG-1 float (FP_BASE for NREG=64).
//   - Reset values of the stack pointer (r2) and heap pointer (r3).
//   - wb_port_t: one writeback port (en/addr/data) at the default geometry.
package vliw_rf_pkg;

    localparam int          NREG_DEFAULT    = 64;
    localparam int          INT_BASE        = 0;
    localparam int          FP_BASE         = 32;
    localparam int          REG_SP          = 2;
    localparam int          REG_HP          = 3;
    localparam logic [31:0] SP_INIT_DEFAULT = 32'h01ff_ffff;
    localparam logic [31:0] HP_INIT_DEFAULT = 32'h0100_0000;

    typedef logic [5:0] reg_addr_t;

    typedef struct packed {
        logic        en;
        reg_addr_t   addr;
        logic [31:0] data;
    } wb_port_t;

endpackage

// File: rtl/vliw_regfile_sb_arb.sv
// rf_wb_arbiter: resolves the NWRITE writeback ports against one address.
//   addr    in  AW           address being resolved
//   wb_en   in  NWRITE       writeback valid per port
//   wb_addr in  NWRITE*AW    packed writeback addresses
//   wb_data in  NWRITE*DW    packed writeback data
//   hit     out 1            some enabled port targets addr
//   data    out DW           data of the highest-index matching port
// Instanced once per register for the commit path and, with the bypass
// build, once per read port for forwarding, so both see the same winner.
module rf_wb_arbiter
    import vliw_rf_pkg::*;
#(
    parameter int NWRITE = 4,
    parameter int AW     = 6,
    parameter int DW     = 32
) (
    input  logic [AW-1:0]        addr,
    input  logic [NWRITE-1:0]    wb_en,
    input  logic [NWRITE*AW-1:0] wb_addr,
    input  logic [NWRITE*DW-1:0] wb_data,
    output logic                 hit,
    output logic [DW-1:0]        data
);

    // Ascending scan: a later (higher) port overwrites earlier matches.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < NWRITE; k++) begin
            if (wb_en[k] && (wb_addr[k*AW +: AW] == addr)) begin
                hit  = 1'b1;
                data = wb_data[k*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/vliw_regfile_sb.sv
// vliw_regfile_sb: unified integer/float register file with a per-register
// scoreboard for the VLIW issue stage.
//   clk       in  1          clock
//   rst       in  1          synchronous active-high reset
//   rs_addr   in  NREAD*AW   packed read addresses
//   rs_data   out NREAD*DW   packed read data (combinational)
//   rs_busy   out NREAD      read register has a pending producer
//   wb_en     in  NWRITE     writeback valid per port
//   wb_addr   in  NWRITE*AW  writeback destinations
//   wb_data   in  NWRITE*DW  writeback data
//   iss_en    in  NWRITE     issue valid per port (marks iss_addr busy)
//   iss_addr  in  NWRITE*AW  issued destinations
//   any_busy  out 1          OR of all busy bits (drain / fence)
// Optional: define REGFILE_BYPASS_EN for same-cycle writeback forwarding.
module vliw_regfile_sb
    import vliw_rf_pkg::*;
#(
    parameter int              NREAD   = 8,
    parameter int              NWRITE  = 4,
    parameter int              NREG    = NREG_DEFAULT,
    parameter int              AW      = $clog2(NREG),
    parameter int              DW      = 32,
    parameter logic [DW-1:0]   SP_INIT = SP_INIT_DEFAULT,
    parameter logic [DW-1:0]   HP_INIT = HP_INIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREAD*AW-1:0]  rs_addr,
    output logic [NREAD*DW-1:0]  rs_data,
    output logic [NREAD-1:0]     rs_busy,
    input  logic [NWRITE-1:0]    wb_en,
    input  logic [NWRITE*AW-1:0] wb_addr,
    input  logic [NWRITE*DW-1:0] wb_data,
    input  logic [NWRITE-1:0]    iss_en,
    input  logic [NWRITE*AW-1:0] iss_addr,
    output logic                 any_busy
);

    logic [DW-1:0]   mem [NREG];
    logic [NREG-1:0] busy;

    // Storage: register 0 is hardwired zero and never busy, so it has no
    // flops; every other register owns its data word and busy bit.
    for (genvar r = 0; r < NREG; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign mem[r]  = '0;
            assign busy[r] = 1'b0;
        end else begin : g_live
            localparam logic [DW-1:0] RST_VAL = (r == REG_SP) ? SP_INIT :
                                                (r == REG_HP) ? HP_INIT : '0;
            logic [DW-1:0] q;
            logic [DW-1:0] wd;
            logic          b;
            logic          hit;
            logic          set;

            rf_wb_arbiter #(.NWRITE(NWRITE), .AW(AW), .DW(DW)) u_arb (
                .addr    (AW'(r)),
                .wb_en   (wb_en),
                .wb_addr (wb_addr),
                .wb_data (wb_data),
                .hit     (hit),
                .data    (wd)
            );

            always_comb begin
                set = 1'b0;
                for (int k = 0; k < NWRITE; k++)
                    if (iss_en[k] && (iss_addr[k*AW +: AW] == AW'(r)))
                        set = 1'b1;
            end

            // Set after clear: a new producer issued in the same cycle
            // as the old one's writeback keeps the register busy.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= RST_VAL;
                    b <= 1'b0;
                end else begin
                    if (hit)
                        q <= wd;
                    b <= (b & ~hit) | set;
                end
            end

            assign mem[r]  = q;
            assign busy[r] = b;
        end
    end

    // Read ports. Address 0 needs no special case: mem[0]/busy[0] are zero.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rs_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        logic          byp_hit;
        logic [DW-1:0] byp_d;
        logic          iss_hit;
        logic          fwd;

        rf_wb_arbiter #(.NWRITE(NWRITE), .AW(AW), .DW(DW)) u_byp (
            .addr    (a),
            .wb_en   (wb_en),
            .wb_addr (wb_addr),
            .wb_data (wb_data),
            .hit     (byp_hit),
            .data    (byp_d)
        );

        always_comb begin
            iss_hit = 1'b0;
            for (int k = 0; k < NWRITE; k++)
                if (iss_en[k] && (iss_addr[k*AW +: AW] == a))
                    iss_hit = 1'b1;
        end

        // While forwarding, the value is already in hand; only a new
        // producer issued this same cycle keeps the operand busy.
        assign fwd                 = byp_hit && (a != '0);
        assign rs_data[i*DW +: DW] = fwd ? byp_d   : mem[a];
        assign rs_busy[i]          = fwd ? iss_hit : busy[a];
`else
        assign rs_data[i*DW +: DW] = mem[a];
        assign rs_busy[i]          = busy[a];
`endif
    end

    assign any_busy = |busy;

endmodule
